// File: rtl/unified_mem.sv
// Unified byte-addressed memory for the SimpleCPU core: one registered load/store
// port, one registered big-endian multi-byte fetch port, optional zero-fill after reset.
module unified_mem #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int INS_BYTES      = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        busy,
    input  logic                        d_req,
    input  logic                        d_we,
    input  logic [ADDR_W-1:0]           d_addr,
    input  logic [DATA_W-1:0]           d_din,
    output logic [DATA_W-1:0]           d_dout,
    output logic                        d_ack,
    input  logic                        i_req,
    input  logic [ADDR_W-1:0]           i_addr,
    output logic [DATA_W*INS_BYTES-1:0] i_ins,
    output logic                        i_valid
);
    // state   | meaning
    // S_CLEAR | zero-filling mem[clr_cnt], one location per cycle; requests dropped
    // S_IDLE  | servicing data and fetch requests

    localparam int DEPTH = 1 << ADDR_W;
    localparam int INS_W = DATA_W * INS_BYTES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
    logic              clr_we;
    logic              d_go, i_go;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [INS_W-1:0]  fetch_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) state <= S_CLEAR;
            else                state <= S_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        clr_we     = 1'b0;
        d_go       = 1'b0;
        i_go       = 1'b0;
        case (state)
            S_CLEAR: begin
                clr_we     = 1'b1;
                clr_cnt_nx = clr_cnt + ADDR_W'(1);
                if (clr_cnt == LAST_ADDR) state_nx = S_IDLE;
            end
            S_IDLE: begin
                d_go = d_req;
                i_go = i_req;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state == S_CLEAR);

    // Reset never touches the array; only the clear sequence or a data write does.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we)
                mem[clr_cnt] <= '0;
            else if (d_go && d_we)
                mem[d_addr] <= d_din;
        end
    end

    // Big-endian gather with modulo-DEPTH wrap; reads the pre-write array contents.
    always_comb begin
        fetch_word = '0;
        for (int k = 0; k < INS_BYTES; k++)
            fetch_word[(INS_BYTES-1-k)*DATA_W +: DATA_W] = mem[i_addr + ADDR_W'(k)];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_dout  <= '0;
            i_ins   <= '0;
            d_ack   <= 1'b0;
            i_valid <= 1'b0;
        end else begin
            d_ack   <= d_go;
            i_valid <= i_go;
            if (d_go) d_dout <= d_we ? d_din : mem[d_addr];
            if (i_go) i_ins  <= fetch_word;
        end
    end

endmodule

// File: tb/tb_unified_mem.sv
// Bench for unified_mem: default instance checked every cycle against a byte-array
// model, plus INS_BYTES=3 and CLEAR_ON_RESET=0 instances with directed checks.
module tb_unified_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // default instance
    logic        rst_n, busy, d_req, d_we, d_ack, i_req, i_valid;
    logic [7:0]  d_addr, d_din, d_dout, i_addr;
    logic [15:0] i_ins;

    unified_mem u_dut (
        .clk(clk), .rst_n(rst_n), .busy(busy),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_din(d_din),
        .d_dout(d_dout), .d_ack(d_ack),
        .i_req(i_req), .i_addr(i_addr), .i_ins(i_ins), .i_valid(i_valid)
    );

    // three-byte fetch instance
    logic        b3_busy, b3_dreq, b3_dwe, b3_dack, b3_ireq, b3_ival;
    logic [7:0]  b3_daddr, b3_ddin, b3_ddout, b3_iaddr;
    logic [23:0] b3_ins;

    unified_mem #(.INS_BYTES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .busy(b3_busy),
        .d_req(b3_dreq), .d_we(b3_dwe), .d_addr(b3_daddr), .d_din(b3_ddin),
        .d_dout(b3_ddout), .d_ack(b3_dack),
        .i_req(b3_ireq), .i_addr(b3_iaddr), .i_ins(b3_ins), .i_valid(b3_ival)
    );

    // no-clear instance
    logic        nc_rst_n, nc_busy, nc_dreq, nc_dwe, nc_dack, nc_ireq, nc_ival;
    logic [7:0]  nc_daddr, nc_ddin, nc_ddout, nc_iaddr;
    logic [15:0] nc_ins;

    unified_mem #(.CLEAR_ON_RESET(1'b0)) u_dut_nc (
        .clk(clk), .rst_n(nc_rst_n), .busy(nc_busy),
        .d_req(nc_dreq), .d_we(nc_dwe), .d_addr(nc_daddr), .d_din(nc_ddin),
        .d_dout(nc_ddout), .d_ack(nc_dack),
        .i_req(nc_ireq), .i_addr(nc_iaddr), .i_ins(nc_ins), .i_valid(nc_ival)
    );

    // Behavioural model of the default instance: memory becomes all-zero once
    // 256 clear cycles have elapsed since the last reset; then requests complete next cycle.
    logic [7:0]  mm [256];
    bit          live = 1'b0;
    bit          e_busy, e_ack, e_val;
    int          clr_left;
    logic [7:0]  e_dout, a1;
    logic [15:0] e_ins;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                live = 1'b1; e_busy = 1'b1; clr_left = 256;
                e_ack = 1'b0; e_val = 1'b0; e_dout = 8'h00; e_ins = 16'h0000;
            end else if (live) begin
                e_ack = 1'b0; e_val = 1'b0;
                if (e_busy) begin
                    clr_left--;
                    if (clr_left == 0) begin
                        e_busy = 1'b0;
                        foreach (mm[k]) mm[k] = 8'h00;
                    end
                end else begin
                    if (i_req) begin
                        a1 = i_addr + 8'd1;
                        e_ins = {mm[i_addr], mm[a1]};
                        e_val = 1'b1;
                    end
                    if (d_req) begin
                        e_ack = 1'b1;
                        if (d_we) begin
                            mm[d_addr] = d_din;
                            e_dout = d_din;
                        end else begin
                            e_dout = mm[d_addr];
                        end
                    end
                end
            end
            #1;
            if (live) begin
                chk("busy",    {31'd0, busy},    {31'd0, e_busy});
                chk("d_ack",   {31'd0, d_ack},   {31'd0, e_ack});
                chk("i_valid", {31'd0, i_valid}, {31'd0, e_val});
                chk("d_dout",  {24'd0, d_dout},  {24'd0, e_dout});
                chk("i_ins",   {16'd0, i_ins},   {16'd0, e_ins});
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic data_op(input logic we, input logic [7:0] a, input logic [7:0] v);
        d_req = 1'b1; d_we = we; d_addr = a; d_din = v;
        nxt();
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a);
        i_req = 1'b1; i_addr = a;
        nxt();
        i_req = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            if (n == 10) begin
                d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_din = 8'hEE;
            end else begin
                d_req = 1'b0; d_we = 1'b0;
            end
            nxt();
        end
        d_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_din = 8'h00;
        i_req = 1'b0; i_addr = 8'h00;
        b3_dreq = 1'b0; b3_dwe = 1'b0; b3_daddr = 8'h00; b3_ddin = 8'h00;
        b3_ireq = 1'b0; b3_iaddr = 8'h00;
        nc_rst_n = 1'b0; nc_dreq = 1'b0; nc_dwe = 1'b0; nc_daddr = 8'h00; nc_ddin = 8'h00;
        nc_ireq = 1'b0; nc_iaddr = 8'h00;

        nxt(); nxt();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_dout", {24'd0, d_dout}, 32'd0);
        rst_n = 1'b1; nc_rst_n = 1'b1;

        // full clear, with a write attempted during it
        count_busy(n);
        chk("clear_len", n, 32'd256);
        data_op(1'b0, 8'h30, 8'h00);
        chk("drop_write", {24'd0, d_dout}, 32'h00);
        for (int a = 0; a < 256; a += 2) begin
            fetch(8'(a));
            chk("clear_fetch", {16'd0, i_ins}, 32'h0000);
        end

        // reset mid-clear restarts the full sequence
        rst_n = 1'b0; nxt(); rst_n = 1'b1;
        for (int c = 0; c < 100; c++) nxt();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0; nxt(); rst_n = 1'b1;
        count_busy(n);
        chk("reclear_len", n, 32'd256);

        // data port
        data_op(1'b1, 8'h10, 8'hA5);
        chk("wr_ack", {31'd0, d_ack}, 32'd1);
        chk("wr_dout", {24'd0, d_dout}, 32'hA5);
        data_op(1'b0, 8'h10, 8'h00);
        chk("rd_a5", {24'd0, d_dout}, 32'hA5);
        data_op(1'b0, 8'h11, 8'h00);
        chk("rd_untouched", {24'd0, d_dout}, 32'h00);
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_din = 8'hC1; nxt();
        chk("b2b_ack0", {31'd0, d_ack}, 32'd1);
        d_addr = 8'h21; d_din = 8'hC2; nxt();
        chk("b2b_ack1", {31'd0, d_ack}, 32'd1);
        chk("b2b_dout1", {24'd0, d_dout}, 32'hC2);
        d_req = 1'b0; d_we = 1'b0; nxt();
        chk("b2b_ack_end", {31'd0, d_ack}, 32'd0);
        chk("hold_dout", {24'd0, d_dout}, 32'hC2);

        // fetch with wrap
        data_op(1'b1, 8'hFF, 8'h12);
        data_op(1'b1, 8'h00, 8'h34);
        fetch(8'hFF);
        chk("wrap_valid", {31'd0, i_valid}, 32'd1);
        chk("wrap_ins", {16'd0, i_ins}, 32'h1234);
        nxt();
        chk("valid_pulse", {31'd0, i_valid}, 32'd0);
        chk("hold_ins", {16'd0, i_ins}, 32'h1234);

        // collision: fetch sees pre-write contents
        data_op(1'b1, 8'h40, 8'h11);
        data_op(1'b1, 8'h41, 8'h22);
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h41; d_din = 8'h99;
        i_req = 1'b1; i_addr = 8'h40;
        nxt();
        d_req = 1'b0; d_we = 1'b0; i_req = 1'b0;
        chk("coll_ins", {16'd0, i_ins}, 32'h1122);
        chk("coll_ack", {31'd0, d_ack}, 32'd1);
        fetch(8'h40);
        chk("coll_after", {16'd0, i_ins}, 32'h1199);

        // three-byte fetch (cleared alongside the default instance)
        chk("b3_idle", {31'd0, b3_busy}, 32'd0);
        b3_dreq = 1'b1; b3_dwe = 1'b1;
        b3_daddr = 8'hFF; b3_ddin = 8'h12; nxt();
        b3_daddr = 8'h00; b3_ddin = 8'h34; nxt();
        b3_daddr = 8'h01; b3_ddin = 8'h56; nxt();
        b3_dreq = 1'b0; b3_dwe = 1'b0;
        b3_ireq = 1'b1; b3_iaddr = 8'hFF; nxt();
        b3_ireq = 1'b0;
        chk("b3_valid", {31'd0, b3_ival}, 32'd1);
        chk("b3_ins", {8'd0, b3_ins}, 32'h123456);

        // no-clear instance: contents survive reset
        chk("nc_busy0", {31'd0, nc_busy}, 32'd0);
        nc_dreq = 1'b1; nc_dwe = 1'b1; nc_daddr = 8'h05; nc_ddin = 8'h7E; nxt();
        nc_dreq = 1'b0; nc_dwe = 1'b0;
        chk("nc_wr_dout", {24'd0, nc_ddout}, 32'h7E);
        nc_rst_n = 1'b0; nxt();
        chk("nc_busy_rst", {31'd0, nc_busy}, 32'd0);
        chk("nc_dout_rst", {24'd0, nc_ddout}, 32'h00);
        nc_rst_n = 1'b1; nxt();
        chk("nc_busy_after", {31'd0, nc_busy}, 32'd0);
        nc_dreq = 1'b1; nc_daddr = 8'h05; nxt();
        nc_dreq = 1'b0;
        chk("nc_ack", {31'd0, nc_dack}, 32'd1);
        chk("nc_preserved", {24'd0, nc_ddout}, 32'h7E);

        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
